// File: rtl/mux.sv
// Two-input, per-bit select used in the LFSR datapath (seed/load vs. shift/feedback).
// p is purely combinational; p_q/s_q are registered copies for downstream logic.
module mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             s,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] p_q,
    output logic             s_q
);

    logic [WIDTH-1:0] p_d;
    logic             s_d;

    // The conditional operator merges x/y per bit on an unknown select
    // (equal bits survive, differing bits go X) rather than defaulting to x.
    assign p_d = s ? y : x;
    assign s_d = s;
    assign p   = p_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            s_q <= 1'b0;
        end else begin
            p_q <= p_d;
            s_q <= s_d;
        end
    end

endmodule

// File: tb/tb_mux.sv
// Directed-vector bench for mux: a 1-bit instance and an 8-bit instance
// share clock and reset; expected values are hand-computed constants.
module tb_mux;

    logic       clk;
    logic       rst;
    logic       x1, y1, s1;
    logic       p1, p1_q, s1_q;
    logic [7:0] x8, y8;
    logic       s8;
    logic [7:0] p8, p8_q;
    logic       s8_q;

    int checks;
    int failures;

    mux u_mux1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .s(s1),
        .p(p1), .p_q(p1_q), .s_q(s1_q)
    );

    mux #(.WIDTH(8)) u_mux8 (
        .clk(clk), .rst(rst), .x(x8), .y(y8), .s(s8),
        .p(p8), .p_q(p8_q), .s_q(s8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        x1 = 1'b0; y1 = 1'b0; s1 = 1'b0;
        x8 = 8'h00; y8 = 8'h00; s8 = 1'b0;

        // combinational select, 2 ns spacing
        #2 chk("p_init", {7'b0, p1}, 8'h00);
        x1 = 1'b1; y1 = 1'b0; s1 = 1'b0;
        #2 chk("p_x_sel_1", {7'b0, p1}, 8'h01);
        x1 = 1'b0; y1 = 1'b1; s1 = 1'b0;
        #2 chk("p_x_sel_0", {7'b0, p1}, 8'h00);
        x1 = 1'b1; y1 = 1'b0; s1 = 1'b1;
        #2 chk("p_y_sel_0", {7'b0, p1}, 8'h00);
        x1 = 1'b0; y1 = 1'b1; s1 = 1'b1;
        #2 chk("p_y_sel_1", {7'b0, p1}, 8'h01);

        // registered outputs cleared by reset
        @(negedge clk);
        edge_sample();
        chk("rst_p_q",   {7'b0, p1_q}, 8'h00);
        chk("rst_s_q",   {7'b0, s1_q}, 8'h00);
        chk("rst_p8_q",  p8_q,         8'h00);
        chk("rst_s8_q",  {7'b0, s8_q}, 8'h00);

        // first edge after reset release captures p immediately
        @(negedge clk);
        rst = 1'b0; x1 = 1'b1; y1 = 1'b0; s1 = 1'b0;
        edge_sample();
        chk("reg_x_p_q", {7'b0, p1_q}, 8'h01);
        chk("reg_x_s_q", {7'b0, s1_q}, 8'h00);

        @(negedge clk);
        s1 = 1'b1;
        edge_sample();
        chk("reg_y_p_q", {7'b0, p1_q}, 8'h00);
        chk("reg_y_s_q", {7'b0, s1_q}, 8'h01);

        // mid-operation reset with p = 1; p keeps tracking inputs
        @(negedge clk);
        s1 = 1'b1; x1 = 1'b0; y1 = 1'b1; rst = 1'b1;
        #1 chk("p_in_rst_pre", {7'b0, p1}, 8'h01);
        edge_sample();
        chk("mid_rst_p_q", {7'b0, p1_q}, 8'h00);
        chk("mid_rst_s_q", {7'b0, s1_q}, 8'h00);
        chk("p_in_rst",    {7'b0, p1},   8'h01);

        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        chk("post_rst_p_q", {7'b0, p1_q}, 8'h01);
        chk("post_rst_s_q", {7'b0, s1_q}, 8'h01);

        // 8-bit instance
        @(negedge clk);
        x8 = 8'hA5; y8 = 8'h3C; s8 = 1'b0;
        #2 chk("p8_x", p8, 8'hA5);
        s8 = 1'b1;
        #2 chk("p8_y", p8, 8'h3C);
        edge_sample();
        chk("p8_q_y", p8_q,         8'h3C);
        chk("s8_q_1", {7'b0, s8_q}, 8'h01);

        @(negedge clk);
        s8 = 1'b0;
        edge_sample();
        chk("p8_q_x", p8_q, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
